serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_ctrl_pkg.sv | 21 ++
 rtl/serial_adder_ctrl_bit_full_adder.sv | 26 ++
 rtl/serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_ctrl_pkg.sv
// Shared definitions for the serial controller family: FSM state
// encoding and a helper to size bit counters.
package serial_ctrl_pkg;

  // State encoding shared by all serial controllers
  localparam logic [1:0] SC_IDLE = 2'd0;
  localparam logic [1:0] SC_RUN  = 2'd1;
  localparam logic [1:0] SC_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = SC_IDLE,
    ST_RUN  = SC_RUN,
    ST_DONE = SC_DONE
  } sc_state_e;

  // Width of a counter that indexes bits 0..w-1 (ceil(log2(w)), at least 1)
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_bit_full_adder.sv
// One-bit full adder built from two half-add stages and a carry OR.
// Purely combinational; the serial controller owns all state.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p;   // first half-add sum (propagate)
  logic g1;  // first half-add carry (generate)
  logic g2;  // second half-add carry

  // First half-add stage on the operand bits
  assign p  = a ^ b;
  assign g1 = a & b;

  // Second half-add stage folds in the incoming carry
  assign s  = p ^ c;
  assign g2 = p & c;

  // Either stage may produce the outgoing carry, never both
  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: computes OpA+OpB+CarryIn one bit per
// cycle, LSB first, and pulses Done when the result is ready.
// Optional feature: define SERIAL_ADDER_CTRL_OVF_EN to add the signed
// Overflow output.
module serial_adder_ctrl
  import serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sc_state_e        state_reg;
  logic [WIDTH-1:0] a_reg;      // operand A, shifted right each RUN cycle
  logic [WIDTH-1:0] b_reg;      // operand B, shifted right each RUN cycle
  logic             carry_reg;  // running carry between bit steps
  logic [CW-1:0]    cnt_reg;    // index of the bit being processed
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             done_reg;

  logic             sum_bit;
  logic             carry_next;

  // Single-bit add step on the current LSBs and the running carry
  bit_full_adder u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .c  (carry_reg),
    .s  (sum_bit),
    .co (carry_next)
  );

`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic ovf_reg;

  // Signed overflow: carry into the MSB differs from carry out of it.
  // Tracks every step; the value after the last bit is the result.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && Start) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      ovf_reg <= carry_reg ^ carry_next;
    end
  end

  assign Overflow = ovf_reg;
`endif

  // Control FSM together with operand, carry, counter and result registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            a_reg     <= OpA;
            b_reg     <= OpB;
            carry_reg <= CarryIn;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          // New sum bit enters at the MSB so bit 0 lands at Sum[0] last
          sum_reg   <= {sum_bit, sum_reg[WIDTH-1:1]};
          a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
          b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
          carry_reg <= carry_next;
          cout_reg  <= carry_next;
          if (cnt_reg == LAST_BIT) begin
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          // Result is already stable; announce it as we return to idle
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy     = (state_reg != ST_IDLE);
  assign Done     = done_reg;
  assign Sum      = sum_reg;
  assign CarryOut = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic         CarryIn;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         CarryOut;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic         Overflow;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .OpA      (OpA),
    .OpB      (OpB),
    .CarryIn  (CarryIn),
    .Busy     (Busy),
    .Done     (Done),
    .Sum      (Sum),
    .CarryOut (CarryOut)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    ,
    .Overflow (Overflow)
`endif
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: Start for one edge, then wait for Done
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_sum, input logic exp_co,
                        input logic exp_ovf);
    int n;
    int busy_cnt;
    Start = 1'b1; OpA = a; OpB = b; CarryIn = cin;
    tick();                                  // edge 0: accepted
    Start = 1'b0; OpA = ~a; OpB = b ^ 8'h5A; CarryIn = ~cin;
    check({tag, " sum_cleared"}, 32'(Sum), 32'h0);
    n = 0;
    busy_cnt = 0;
    while (!Done && n < 20) begin
      if (Busy) busy_cnt++;
      tick();
      n++;
    end
    check({tag, " done_edge"}, 32'(n), 32'(W + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
    check({tag, " sum"}, 32'(Sum), 32'(exp_sum));
    check({tag, " carryout"}, 32'(CarryOut), 32'(exp_co));
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    check({tag, " overflow"}, 32'(Overflow), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    $display("op %s: %02h+%02h+%0d -> sum=%02h co=%0d after %0d edges", tag, a, b, cin, Sum, CarryOut, n);
    tick();
    check({tag, " done_one_cycle"}, 32'(Done), 32'h0);
  endtask

  initial begin
    int done_cnt;
    int done_edge;
    int late_busy;
    logic [W-1:0] sum_at_done;

    Rst_n = 1'b0; Start = 1'b0; OpA = '0; OpB = '0; CarryIn = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(Busy), 32'h0);
    check("reset done", 32'(Done), 32'h0);
    check("reset sum", 32'(Sum), 32'h0);
    check("reset co", 32'(CarryOut), 32'h0);
    Rst_n = 1'b1;
    tick();

    run_op("03+05",    8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0);
    run_op("FF+01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("FF+FF+1",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("12+34+1",  8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    run_op("5A+A5+1",  8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("7F+01",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("80+80",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Start pulsed mid-run must be ignored and not queued
    Start = 1'b1; OpA = 8'h21; OpB = 8'h13; CarryIn = 1'b0;
    tick();                                  // edge 0
    Start = 1'b0;
    done_cnt = 0; done_edge = -1; late_busy = 0; sum_at_done = '0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 4) begin Start = 1'b1; OpA = 8'hEE; OpB = 8'h77; CarryIn = 1'b1; end
      tick();                                // edge i
      Start = 1'b0;
      if (Done) begin done_cnt++; done_edge = i; sum_at_done = Sum; end
      if (done_edge >= 0 && Busy) late_busy++;
    end
    check("midstart done_count", 32'(done_cnt), 32'h1);
    check("midstart done_edge", 32'(done_edge), 32'(W + 1));
    check("midstart sum", 32'(sum_at_done), 32'h34);
    check("midstart no_second_op", 32'(late_busy), 32'h0);
    $display("midstart: dones=%0d edge=%0d sum=%02h", done_cnt, done_edge, sum_at_done);

    // Reset at edge 5 of a run aborts it
    Start = 1'b1; OpA = 8'h44; OpB = 8'h11; CarryIn = 1'b0;
    tick();                                  // edge 0
    Start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    Rst_n = 1'b0;
    tick();                                  // edge 5
    Rst_n = 1'b1;
    check("abort busy", 32'(Busy), 32'h0);
    check("abort done", 32'(Done), 32'h0);
    check("abort sum", 32'(Sum), 32'h0);
    check("abort co", 32'(CarryOut), 32'h0);
    $display("abort: busy=%0d done=%0d sum=%02h co=%0d", Busy, Done, Sum, CarryOut);
    run_op("post_reset", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // Start held high: one operation every W+2 cycles
    Start = 1'b1; OpA = 8'h10; OpB = 8'h20; CarryIn = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();                                // edge i
      if (Done) begin
        done_cnt++;
        check("held done_phase", 32'(i % (W + 2)), 32'(W + 1));
        check("held sum", 32'(Sum), 32'h30);
        check("held co", 32'(CarryOut), 32'h0);
        $display("held: done at edge %0d sum=%02h", i, Sum);
      end
    end
    Start = 1'b0;
    check("held done_count", 32'(done_cnt), 32'h3);
    tick();
    check("held idle_after", 32'(Busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
